// File: rtl/dac_spi_receiver.sv
// dac_spi_receiver
// In-fabric model of a serial DAC: receives CS_N/SCLK/DIN/LDAC_N frames,
// decodes them into per-channel input registers and DAC registers, and
// reports frame completion (valid or wrongly sized) as single-cycle pulses.
//
// Handshake: there is no valid/ready flow control on this block. The serial
// side is a free-running master; frame_valid / frame_error are one-cycle
// strobes with no backpressure, and last_* / dac_out are registered values
// that stay stable until the next qualifying event.
module dac_spi_receiver #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               dac_cs_n,
  input  logic                               dac_sclk,
  input  logic                               dac_din,
  input  logic                               dac_ldac_n,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] dac_out,
  output logic                               frame_valid,
  output logic                               frame_error,
  output logic [3:0]                         last_cmd,
  output logic [3:0]                         last_addr,
  output logic [DATA_WIDTH-1:0]              last_data,
  output logic                               busy,
  output logic [1:0]                         state_dbg
);

  localparam int FRAME_BITS = DATA_WIDTH + 8;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_t;

  // Synchronizer and history flops
  logic cs_s1, cs_s2, cs_h;
  logic ldac_s1, ldac_s2, ldac_h;
  logic sclk_s1, sclk_s2, sclk_h;
  logic din_s1, din_s2;

  // Registered edge strobes, all aligned to the same cycle
  logic sclk_fall_q, din_q, cs_fall_q, cs_rise_q, ldac_fall_q;
  logic primed, cs_armed;

  // FSM and datapath state
  state_t                  state_q, state_nxt;
  logic [CNT_W-1:0]        bit_cnt, cnt_nxt;
  logic [FRAME_BITS-1:0]   shreg, sh_nxt;
  logic                    do_decode, frame_ok, frame_bad;

  logic [3:0]              dec_cmd, dec_addr;
  logic [DATA_WIDTH-1:0]   dec_data;
  logic                    addr_ok;
  logic                    copy_all;

  logic [DATA_WIDTH-1:0]   in_reg  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   dac_reg [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   in_nxt  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   dac_nxt [NUM_CHANNELS];

  // Two-flop synchronizers plus one history flop per edge-detected input;
  // CS_N and LDAC_N idle high so they reset high to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_h    <= 1'b1;
      ldac_s1 <= 1'b1;
      ldac_s2 <= 1'b1;
      ldac_h  <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_h  <= 1'b0;
      din_s1  <= 1'b0;
      din_s2  <= 1'b0;
    end else begin
      cs_s1   <= dac_cs_n;
      cs_s2   <= cs_s1;
      cs_h    <= cs_s2;
      ldac_s1 <= dac_ldac_n;
      ldac_s2 <= ldac_s1;
      ldac_h  <= ldac_s2;
      sclk_s1 <= dac_sclk;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      din_s1  <= dac_din;
      din_s2  <= din_s1;
    end
  end

  // Edge strobes. CS_N falls are only honoured once CS_N has really been
  // sampled high after reset, so a frame in flight across reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_fall_q <= 1'b0;
      din_q       <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      ldac_fall_q <= 1'b0;
      primed      <= 1'b0;
      cs_armed    <= 1'b0;
    end else begin
      sclk_fall_q <= sclk_h & ~sclk_s2 & ~cs_s2;
      din_q       <= din_s2;
      cs_fall_q   <= cs_armed & cs_h & ~cs_s2;
      cs_rise_q   <= ~cs_h & cs_s2;
      ldac_fall_q <= ldac_h & ~ldac_s2;
      primed      <= 1'b1;
      cs_armed    <= cs_armed | (primed & cs_s1);
    end
  end

  // FSM state, bit counter and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state_q <= state_nxt;
      bit_cnt <= cnt_nxt;
      shreg   <= sh_nxt;
    end
  end

  // Next-state logic; a same-cycle SCLK fall is shifted before leaving SHIFT
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = bit_cnt;
    sh_nxt    = shreg;
    do_decode = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall_q) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          sh_nxt    = '0;
        end
      end
      SHIFT: begin
        if (sclk_fall_q) begin
          sh_nxt = {shreg[FRAME_BITS-2:0], din_q};
          if (bit_cnt != CNT_MAX) begin
            cnt_nxt = bit_cnt + 1'b1;
          end
        end
        if (cs_rise_q) begin
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        do_decode = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign frame_ok  = do_decode && (bit_cnt == CNT_FRAME);
  assign frame_bad = do_decode && (bit_cnt != CNT_FRAME);

  assign dec_cmd  = shreg[FRAME_BITS-1 -: 4];
  assign dec_addr = shreg[FRAME_BITS-5 -: 4];
  assign dec_data = shreg[DATA_WIDTH-1:0];
  assign addr_ok  = ({1'b0, dec_addr} < 5'(NUM_CHANNELS));

  assign busy      = (state_q == SHIFT) || (state_q == DECODE);
  assign state_dbg = state_q;

  // Register file update: the frame write lands in in_nxt first, so an
  // LDAC copy in the same cycle carries the freshly written value.
  always_comb begin
    copy_all = 1'b0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      in_nxt[ch]  = in_reg[ch];
      dac_nxt[ch] = dac_reg[ch];
    end
    if (frame_ok && addr_ok) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (dec_addr == 4'(ch)) begin
          case (dec_cmd)
            4'h0, 4'h2: in_nxt[ch] = dec_data;
            4'h1:       dac_nxt[ch] = in_reg[ch];
            4'h3: begin
              in_nxt[ch]  = dec_data;
              dac_nxt[ch] = dec_data;
            end
            default: ;
          endcase
        end
      end
      if (dec_cmd == 4'h2) begin
        copy_all = 1'b1;
      end
    end
    if (ldac_fall_q) begin
      copy_all = 1'b1;
    end
    if (copy_all) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        dac_nxt[ch] = in_nxt[ch];
      end
    end
  end

  // Input and DAC register banks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        in_reg[ch]  <= '0;
        dac_reg[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        in_reg[ch]  <= in_nxt[ch];
        dac_reg[ch] <= dac_nxt[ch];
      end
    end
  end

  // Frame status strobes and last-frame capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      last_cmd    <= '0;
      last_addr   <= '0;
      last_data   <= '0;
    end else begin
      frame_valid <= frame_ok;
      frame_error <= frame_bad;
      if (frame_ok) begin
        last_cmd  <= dec_cmd;
        last_addr <= dec_addr;
        last_data <= dec_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
    assign dac_out[g*DATA_WIDTH +: DATA_WIDTH] = dac_reg[g];
  end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Bench for dac_spi_receiver: directed frames, an abstract register-file
// model, a per-cycle compare process and a few literal anchor checks.
module tb_dac_spi_receiver;

  localparam int DW = 16;
  localparam int NC = 8;
  localparam int FB = DW + 8;
  localparam int OW = NC * DW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cs_n = 1'b1;
  logic          sclk = 1'b0;
  logic          din = 1'b0;
  logic          ldac_n = 1'b1;
  logic [OW-1:0] dac_out;
  logic          frame_valid, frame_error, busy;
  logic [3:0]    last_cmd, last_addr;
  logic [DW-1:0] last_data;
  logic [1:0]    state_dbg;

  dac_spi_receiver #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC)) dut (
    .clk(clk), .rst(rst),
    .dac_cs_n(cs_n), .dac_sclk(sclk), .dac_din(din), .dac_ldac_n(ldac_n),
    .dac_out(dac_out), .frame_valid(frame_valid), .frame_error(frame_error),
    .last_cmd(last_cmd), .last_addr(last_addr), .last_data(last_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Scoreboard / model state
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] in_m  [NC];
  logic [DW-1:0] dac_m [NC];
  logic [3:0]    lc_m = '0;
  logic [3:0]    la_m = '0;
  logic [DW-1:0] ld_m = '0;
  logic exp_fv = 1'b0;
  logic exp_fe = 1'b0;
  bit   chk_en = 1'b0;
  bit   chk_dac = 1'b1;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] pack_dac();
    logic [OW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*DW +: DW] = dac_m[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      in_m[c]  = '0;
      dac_m[c] = '0;
    end
    lc_m = '0;
    la_m = '0;
    ld_m = '0;
  endtask

  task automatic model_copy_all();
    for (int c = 0; c < NC; c++) dac_m[c] = in_m[c];
  endtask

  // Abstract frame semantics: only exact-length frames do anything
  task automatic model_frame(input int nbits, input logic [31:0] bits);
    int cmd, addr;
    logic [DW-1:0] data;
    if (nbits != FB) return;
    cmd  = int'(bits[23:20]);
    addr = int'(bits[19:16]);
    data = bits[15:0];
    lc_m = 4'(cmd);
    la_m = 4'(addr);
    ld_m = data;
    if (addr >= NC) return;
    case (cmd)
      0: in_m[addr] = data;
      1: dac_m[addr] = in_m[addr];
      2: begin in_m[addr] = data; model_copy_all(); end
      3: begin in_m[addr] = data; dac_m[addr] = data; end
      default: ;
    endcase
  endtask

  // Compare process: every cycle, outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (chk_dac) check("dac_out", dac_out, pack_dac());
      check("frame_valid", OW'(frame_valid), OW'(exp_fv));
      check("frame_error", OW'(frame_error), OW'(exp_fe));
      check("last_cmd", OW'(last_cmd), OW'(lc_m));
      check("last_addr", OW'(last_addr), OW'(la_m));
      check("last_data", OW'(last_data), OW'(ld_m));
    end
  end

  // Driver: shift nbits MSB first, SCLK half period = 4 clk, then release
  // CS_N at a negedge so the next posedge is the first that samples it high.
  task automatic send_frame(input int nbits, input logic [31:0] bits, input bit ldac_same);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      din  = bits[i];
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      if (i == nbits / 2) check("busy_shift", OW'(busy), OW'(1));
    end
    cs_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1 && ldac_same) ldac_n = 1'b0;
      if (k == 4) check("busy_decode", OW'(busy), OW'(1));
      if (k == 5) begin
        model_frame(nbits, bits);
        if (ldac_same) model_copy_all();
        exp_fv = (nbits == FB);
        exp_fe = (nbits != FB);
        check("busy_after", OW'(busy), OW'(0));
      end else begin
        exp_fv = 1'b0;
        exp_fe = 1'b0;
      end
      if (k == 7) ldac_n = 1'b1;
    end
  endtask

  // LDAC pulse: the copy must be visible within 4 clk cycles
  task automatic pulse_ldac();
    @(negedge clk);
    ldac_n  = 1'b0;
    chk_dac = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    model_copy_all();
    chk_dac = 1'b1;
    repeat (3) @(negedge clk);
    ldac_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    model_reset();
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_dac_lit", dac_out, '0);
    check("rst_busy", OW'(busy), OW'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    // cmd3 addr2 0xABCD
    send_frame(24, 32'h32ABCD, 1'b0);
    check("t1_ch2_lit", OW'(dac_out[2*DW +: DW]), OW'(16'hABCD));
    check("t1_others_lit", dac_out & ~(OW'(16'hFFFF) << (2*DW)), '0);

    // cmd0 addr5 0x1234 then LDAC
    send_frame(24, 32'h051234, 1'b0);
    check("t2_ch5_before", OW'(dac_out[5*DW +: DW]), OW'(0));
    pulse_ldac();
    check("t2_ch5_lit", OW'(dac_out[5*DW +: DW]), OW'(16'h1234));

    // Wrongly sized frames
    send_frame(23, 32'h12ABCD, 1'b0);
    send_frame(25, 32'h1_32ABCD, 1'b0);
    check("t3_last_data_lit", OW'(last_data), OW'(16'h1234));

    // Out-of-range address
    send_frame(24, 32'h39FFFF, 1'b0);
    check("t4_last_addr_lit", OW'(last_addr), OW'(9));

    // Unknown command, then cmd0+cmd1 copy of a single channel
    send_frame(24, 32'h701111, 1'b0);
    send_frame(24, 32'h066666, 1'b0);
    send_frame(24, 32'h160000, 1'b0);
    check("t5_ch6_lit", OW'(dac_out[6*DW +: DW]), OW'(16'h6666));

    // Two input writes, then cmd2 updates all DAC regs together
    send_frame(24, 32'h010AAA, 1'b0);
    send_frame(24, 32'h030555, 1'b0);
    check("t6_ch1_pre", OW'(dac_out[1*DW +: DW]), OW'(0));
    send_frame(24, 32'h200001, 1'b0);
    check("t6_ch0_lit", OW'(dac_out[0 +: DW]), OW'(16'h0001));
    check("t6_ch1_lit", OW'(dac_out[1*DW +: DW]), OW'(16'h0AAA));
    check("t6_ch3_lit", OW'(dac_out[3*DW +: DW]), OW'(16'h0555));

    // LDAC coinciding with decode: new data reaches the DAC reg
    send_frame(24, 32'h04BEEF, 1'b1);
    check("t7_ch4_lit", OW'(dac_out[4*DW +: DW]), OW'(16'hBEEF));
    repeat (4) @(negedge clk);

    // Reset after 10 bits with CS_N held low
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      din  = 1'(i & 1);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("t8_rst_dac_lit", dac_out, '0);
    check("t8_rst_last_lit", OW'({last_cmd, last_addr, last_data}), OW'(0));
    check("t8_rst_busy", OW'(busy), OW'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t8_idle_cs_low", OW'(busy), OW'(0));
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t8_idle_cs_high", OW'(busy), OW'(0));

    // A fresh frame after reset works normally
    send_frame(24, 32'h375A5A, 1'b0);
    check("t9_ch7_lit", OW'(dac_out[7*DW +: DW]), OW'(16'h5A5A));
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
